rom_burst_reader: RTL

Read-side initiator for the 16x16 synchronous `rom`. On a `start` request it issues a burst of consecutive ROM reads from a base address, with wrap-around. It captures each word one cycle after the read and delivers the words in order on a valid/ready output stream. A 4-entry buffer absorbs downstream backpressure without dropping or duplicating words. It sits between the `rom` instance and any consumer that needs table data streamed out.

---
 rtl/rom_burst_reader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rom_burst_reader.sv
// Burst read initiator for a synchronous ROM: issues consecutive wrapped reads
// and streams the captured words through a 4-entry valid/ready buffer.
module rom_burst_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              rom_r_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic [ADDR_W:0]            len_q;
  logic [ADDR_W:0]            issued;
  logic                       cap_en;
  logic                       r_last;
  logic                       cap_last;
  logic [3:0][DATA_W-1:0]     fifo_data;
  logic [3:0]                 fifo_last;
  logic [1:0]                 wr_ptr;
  logic [1:0]                 rd_ptr;
  logic [2:0]                 occ;
  logic [3:0]                 inflight;
  logic                       issue;
  logic                       issue_last;
  logic                       done_nxt;
  logic                       load;
  logic                       push;
  logic                       pop;

  // Words buffered plus reads still in the ROM pipeline; bounding this sum
  // by the buffer depth is what keeps the buffer from overflowing.
  assign inflight = {1'b0, occ} + {3'b000, rom_r_en} + {3'b000, cap_en};
  assign push     = cap_en;
  assign pop      = (occ != 3'd0) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    done_nxt   = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            load       = 1'b1;
            issue      = 1'b1;
            issue_last = (length == {{ADDR_W{1'b0}}, 1'b1});
            state_nxt  = RUN;
          end else begin
            done_nxt   = 1'b1;
          end
        end
      end
      RUN: begin
        if (issued == len_q) begin
          state_nxt = DRAIN;
        end else if (inflight < 4'd4) begin
          issue      = 1'b1;
          issue_last = ((issued + {{ADDR_W{1'b0}}, 1'b1}) == len_q);
        end
      end
      DRAIN: begin
        if (!rom_r_en && !cap_en && (occ == 3'd1) && pop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      rom_r_en  <= 1'b0;
      rom_addr  <= '0;
      len_q     <= '0;
      issued    <= '0;
      r_last    <= 1'b0;
      cap_en    <= 1'b0;
      cap_last  <= 1'b0;
      fifo_data <= '0;
      fifo_last <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
    end else begin
      done     <= done_nxt;
      rom_r_en <= issue;
      r_last   <= issue && issue_last;
      cap_en   <= rom_r_en;
      cap_last <= r_last;
      if (load) begin
        len_q    <= length;
        issued   <= {{ADDR_W{1'b0}}, 1'b1};
        rom_addr <= base_addr;
      end else if (issue) begin
        issued   <= issued + {{ADDR_W{1'b0}}, 1'b1};
        rom_addr <= rom_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (push) begin
        fifo_data[wr_ptr] <= rom_data;
        fifo_last[wr_ptr] <= cap_last;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (occ != 3'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid && fifo_last[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (occ == 3'd4)))
    else $error("rom_burst_reader buffer overflow");

endmodule
